// File: rtl/zero_scan.sv
// Multi-cycle zero detector: scans a captured operand CHUNK bits per clock from the LSB.
// Optional trailing-zero count output enabled by defining ZERO_SCAN_TZC_EN.
module zero_scan #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             zero_flag
`ifdef ZERO_SCAN_TZC_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] tz_count
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int TZW    = $clog2(WIDTH + 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("zero_scan: CHUNK must be >= 1 and divide WIDTH (WIDTH >= 1)");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] operand;
    logic [CHUNK-1:0] chunk;
    logic             chunk_hit;
    logic             last_chunk;

    always_comb begin
        chunk = operand[int'(idx) * CHUNK +: CHUNK];
    end

    assign chunk_hit  = (chunk != '0);
    assign last_chunk = (idx == IDXW'(NCHUNK - 1));
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

`ifdef ZERO_SCAN_TZC_EN
    logic [TZW-1:0] lsb_pos;
    logic [TZW-1:0] tz_hit;

    // Descending walk so the lowest set bit is the final assignment.
    always_comb begin
        lsb_pos = '0;
        for (int unsigned i = CHUNK; i > 0; i--) begin
            if (chunk[i-1]) lsb_pos = TZW'(i - 1);
        end
    end

    assign tz_hit = TZW'(idx) * TZW'(CHUNK) + lsb_pos;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            operand   <= '0;
            zero_flag <= 1'b1;
`ifdef ZERO_SCAN_TZC_EN
            tz_count  <= TZW'(WIDTH);
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        operand <= value;
                        idx     <= '0;
                        state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (chunk_hit) begin
                        zero_flag <= 1'b0;
`ifdef ZERO_SCAN_TZC_EN
                        tz_count  <= tz_hit;
`endif
                        state     <= S_DONE;
                    end else if (last_chunk) begin
                        zero_flag <= 1'b1;
`ifdef ZERO_SCAN_TZC_EN
                        tz_count  <= TZW'(WIDTH);
`endif
                        state     <= S_DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zero_scan.sv
// Randomized self-checking bench for zero_scan (WIDTH=32, CHUNK=8).
// Trailing-zero checks are active when ZERO_SCAN_TZC_EN is defined.
module tb_zero_scan;

    localparam int W = 32;
    localparam int C = 8;
    localparam int N = W / C;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        zero_flag;
    logic [5:0]  tz_out;

    int n_vec = 0;
    int n_err = 0;
    bit cur_zf = 1'b1;
    int cur_tz = W;

    always #5 clk = ~clk;

    zero_scan #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .value(value),
        .busy(busy),
        .done(done),
        .zero_flag(zero_flag)
`ifdef ZERO_SCAN_TZC_EN
        ,
        .tz_count(tz_out)
`endif
    );

`ifndef ZERO_SCAN_TZC_EN
    assign tz_out = 6'd32;
`endif

    // Reference: trailing zeros by bit count, latency from the first non-zero chunk.
    function automatic void model(input logic [31:0] v, output bit zf, output int tz, output int lat);
        tz = W;
        for (int b = W - 1; b >= 0; b--) if (v[b]) tz = b;
        zf  = (v == 32'd0);
        lat = zf ? N + 1 : (tz / C) + 2;
    endfunction

    // Drives one start and measures done latency (cycles after the start cycle).
    task automatic do_scan(input logic [31:0] v, input bit hold, input int inj, input logic [31:0] inj_val,
                           output int lat, output bit zf, output int tz, output bit busy_ok, output bit hold_ok);
        @(negedge clk);
        start = 1'b1;
        value = v;
        lat = 0; zf = 1'b0; tz = -1; busy_ok = 1'b1; hold_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = hold || (i == inj);
            value = (i == inj) ? inj_val : $urandom;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = i;
                zf  = zero_flag;
                tz  = int'(tz_out);
                break;
            end
            if (zero_flag !== cur_zf) hold_ok = 1'b0;
`ifdef ZERO_SCAN_TZC_EN
            if (int'(tz_out) != cur_tz) hold_ok = 1'b0;
`endif
        end
    endtask

    task automatic test_reset();
        bit quiet;
        rst = 1'b1; start = 1'b0; value = '0;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (zero_flag !== 1'b1) begin n_err++; $display("FAIL reset_zero_flag: got %b expected 1", zero_flag); end
`ifdef ZERO_SCAN_TZC_EN
        n_vec++; if (tz_out !== 6'd32) begin n_err++; $display("FAIL reset_tz: got %0d expected 32", tz_out); end
`endif
        rst = 1'b0;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        n_vec++; if (quiet !== 1'b1) begin n_err++; $display("FAIL idle_quiet: got %b expected 1", quiet); end
        cur_zf = 1'b1; cur_tz = W;
    endtask

    task automatic test_directed();
        logic [31:0] tv [3] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000};
        int          tl [3] = '{5, 2, 5};
        bit          tf [3] = '{1'b1, 1'b0, 1'b0};
        int          tt [3] = '{32, 0, 31};
        int lat; bit zf; int tz; bit bok; bit hok;
        for (int k = 0; k < 3; k++) begin
            do_scan(tv[k], 1'b0, 0, 32'd0, lat, zf, tz, bok, hok);
            n_vec++; if (lat != tl[k]) begin n_err++; $display("FAIL dir%0d_latency: got %0d expected %0d", k, lat, tl[k]); end
            n_vec++; if (zf !== tf[k]) begin n_err++; $display("FAIL dir%0d_zero_flag: got %b expected %b", k, zf, tf[k]); end
`ifdef ZERO_SCAN_TZC_EN
            n_vec++; if (tz != tt[k]) begin n_err++; $display("FAIL dir%0d_tz: got %0d expected %0d", k, tz, tt[k]); end
`endif
            n_vec++; if (bok !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy: got %b expected 1", k, bok); end
            n_vec++; if (hok !== 1'b1) begin n_err++; $display("FAIL dir%0d_hold: got %b expected 1", k, hok); end
            cur_zf = tf[k]; cur_tz = tt[k];
        end
    endtask

    task automatic test_ignore_start();
        int lat; bit zf; int tz; bit bok; bit hok; bit extra;
        do_scan(32'h0001_0000, 1'b0, 2, 32'd0, lat, zf, tz, bok, hok);
        n_vec++; if (lat != 4) begin n_err++; $display("FAIL ign_latency: got %0d expected 4", lat); end
        n_vec++; if (zf !== 1'b0) begin n_err++; $display("FAIL ign_zero_flag: got %b expected 0", zf); end
`ifdef ZERO_SCAN_TZC_EN
        n_vec++; if (tz != 16) begin n_err++; $display("FAIL ign_tz: got %0d expected 16", tz); end
`endif
        cur_zf = 1'b0; cur_tz = 16;
        extra = 1'b0;
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
        end
        n_vec++; if (extra !== 1'b0) begin n_err++; $display("FAIL ign_no_second_scan: got %b expected 0", extra); end
    endtask

    task automatic test_mid_reset();
        int lat; bit zf; int tz; bit bok; bit hok; bit extra;
        do_scan(32'h0000_0001, 1'b0, 0, 32'd0, lat, zf, tz, bok, hok);
        n_vec++; if (zf !== 1'b0) begin n_err++; $display("FAIL mr_pre_zero_flag: got %b expected 0", zf); end
        cur_zf = 1'b0; cur_tz = 0;
        @(negedge clk); start = 1'b1; value = 32'd0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mr_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mr_done: got %b expected 0", done); end
        n_vec++; if (zero_flag !== 1'b1) begin n_err++; $display("FAIL mr_zero_flag: got %b expected 1", zero_flag); end
`ifdef ZERO_SCAN_TZC_EN
        n_vec++; if (tz_out !== 6'd32) begin n_err++; $display("FAIL mr_tz: got %0d expected 32", tz_out); end
`endif
        @(negedge clk); rst = 1'b0;
        cur_zf = 1'b1; cur_tz = W;
        extra = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
        end
        n_vec++; if (extra !== 1'b0) begin n_err++; $display("FAIL mr_no_done: got %b expected 0", extra); end
        do_scan(32'h0000_0100, 1'b0, 0, 32'd0, lat, zf, tz, bok, hok);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL mr_after_latency: got %0d expected 3", lat); end
`ifdef ZERO_SCAN_TZC_EN
        n_vec++; if (tz != 8) begin n_err++; $display("FAIL mr_after_tz: got %0d expected 8", tz); end
`endif
        cur_zf = 1'b0; cur_tz = 8;
    endtask

    task automatic test_back_to_back();
        int lat; bit zf; int tz; bit bok; bit hok;
        do_scan(32'h0000_0001, 1'b1, 0, 32'd0, lat, zf, tz, bok, hok);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL b2b0_latency: got %0d expected 2", lat); end
        n_vec++; if (zf !== 1'b0) begin n_err++; $display("FAIL b2b0_zero_flag: got %b expected 0", zf); end
`ifdef ZERO_SCAN_TZC_EN
        n_vec++; if (tz != 0) begin n_err++; $display("FAIL b2b0_tz: got %0d expected 0", tz); end
`endif
        cur_zf = 1'b0; cur_tz = 0;
        do_scan(32'h0000_0000, 1'b1, 0, 32'd0, lat, zf, tz, bok, hok);
        start = 1'b0;
        n_vec++; if (lat != 5) begin n_err++; $display("FAIL b2b1_latency: got %0d expected 5", lat); end
        n_vec++; if (zf !== 1'b1) begin n_err++; $display("FAIL b2b1_zero_flag: got %b expected 1", zf); end
`ifdef ZERO_SCAN_TZC_EN
        n_vec++; if (tz != 32) begin n_err++; $display("FAIL b2b1_tz: got %0d expected 32", tz); end
`endif
        n_vec++; if (hok !== 1'b1) begin n_err++; $display("FAIL b2b1_hold: got %b expected 1", hok); end
        cur_zf = 1'b1; cur_tz = W;
    endtask

    task automatic test_random();
        logic [31:0] v;
        int lat; bit zf; int tz; bit bok; bit hok;
        bit ezf; int etz; int elat; int inj;
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = 32'd1 << $urandom_range(0, 31);
                2: v = 32'd0;
                default: v = ($urandom & 32'hFF) << (8 * $urandom_range(0, 3));
            endcase
            model(v, ezf, etz, elat);
            inj = $urandom_range(0, elat);
            do_scan(v, 1'b0, inj, $urandom, lat, zf, tz, bok, hok);
            n_vec++; if (lat != elat) begin n_err++; $display("FAIL rnd%0d_latency: value %h got %0d expected %0d", k, v, lat, elat); end
            n_vec++; if (zf !== ezf) begin n_err++; $display("FAIL rnd%0d_zero_flag: value %h got %b expected %b", k, v, zf, ezf); end
`ifdef ZERO_SCAN_TZC_EN
            n_vec++; if (tz != etz) begin n_err++; $display("FAIL rnd%0d_tz: value %h got %0d expected %0d", k, v, tz, etz); end
`endif
            n_vec++; if ((bok & hok) !== 1'b1) begin n_err++; $display("FAIL rnd%0d_busy_hold: got %b%b expected 11", k, bok, hok); end
            cur_zf = ezf; cur_tz = etz;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
